// File: rtl/audiosystem_ram_dp_pipe.sv
// -----------------------------------------------------------------------------
// audiosystem_ram_dp_pipe
//
// Parametrised true dual-port RAM with two independent Avalon-MM slave ports
// (A and B) on one clock. Sits between the audio DMA/CPU fabric and the
// sample buffers.
//
//  * Configurable data/address width (DATA_W must be a multiple of 8).
//  * Read pipeline of RD_LAT cycles (1..3) with readdatavalid; readdata is
//    only updated on a valid pulse and holds in between.
//  * Write collisions: when both ports write the same word in the same cycle,
//    port A wins in the lanes both ports enable.
//  * Optional post-reset zero clear (INIT_ZERO=1): one word per cycle for
//    DEPTH cycles while waitrequest is held high on both ports.
//
// Optional feature macro: AUDIOSYS_RAM_FWD_EN
//    defined   : a read on one port that hits the word being written by the
//                other port in the same cycle returns the NEW (merged) word.
//    undefined : such a read returns the OLD word.
//
// Ports:
//    clk              sole clock
//    reset            synchronous, active-high reset
//    a_/b_address     word address (ADDR_W)
//    a_/b_chipselect  port select
//    a_/b_read        read request
//    a_/b_write       write request (wins over read when both are set)
//    a_/b_byteenable  byte lanes (BE_W)
//    a_/b_writedata   write data (DATA_W)
//    a_/b_readdata    read data (DATA_W), registered
//    a_/b_readdatavalid  one-cycle pulse RD_LAT cycles after read accept
//    a_/b_waitrequest stall, high during reset and clear
//    init_done        high once the RAM is usable
// -----------------------------------------------------------------------------
module audiosystem_ram_dp_pipe #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 15,
    parameter int RD_LAT    = 1,
    parameter int INIT_ZERO = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     a_address,
    input  logic                  a_chipselect,
    input  logic                  a_read,
    input  logic                  a_write,
    input  logic [DATA_W/8-1:0]   a_byteenable,
    input  logic [DATA_W-1:0]     a_writedata,
    output logic [DATA_W-1:0]     a_readdata,
    output logic                  a_readdatavalid,
    output logic                  a_waitrequest,
    input  logic [ADDR_W-1:0]     b_address,
    input  logic                  b_chipselect,
    input  logic                  b_read,
    input  logic                  b_write,
    input  logic [DATA_W/8-1:0]   b_byteenable,
    input  logic [DATA_W-1:0]     b_writedata,
    output logic [DATA_W-1:0]     b_readdata,
    output logic                  b_readdatavalid,
    output logic                  b_waitrequest,
    output logic                  init_done
);

    localparam int BE_W  = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    // Overlay the enabled byte lanes of new_word onto old_word.
    function automatic logic [DATA_W-1:0] merge_lanes(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [BE_W-1:0]   be
    );
        logic [DATA_W-1:0] res;
        res = old_word;
        for (int l = 0; l < BE_W; l++) begin
            if (be[l]) begin
                res[8*l +: 8] = new_word[8*l +: 8];
            end else begin
                res[8*l +: 8] = old_word[8*l +: 8];
            end
        end
        return res;
    endfunction

    logic [DATA_W-1:0] mem_r [DEPTH];

    state_t            state_r;
    logic [ADDR_W-1:0] clr_addr_r;
    logic              wait_r;
    logic              init_done_r;

    logic              clr_en_s;
    logic              a_wr_acc_s;
    logic              a_rd_acc_s;
    logic              b_wr_acc_s;
    logic              b_rd_acc_s;
    logic [DATA_W-1:0] a_rd_word_s;
    logic [DATA_W-1:0] b_rd_word_s;

    // Read pipelines: stage RD_LAT-1 drives the outputs directly.
    logic [RD_LAT-1:0] a_pv_r;
    logic [RD_LAT-1:0] b_pv_r;
    logic [DATA_W-1:0] a_pd_r [RD_LAT];
    logic [DATA_W-1:0] b_pd_r [RD_LAT];
    logic [RD_LAT-1:0] a_vchain_s;
    logic [RD_LAT-1:0] b_vchain_s;
    logic [DATA_W-1:0] a_dchain_s [RD_LAT];
    logic [DATA_W-1:0] b_dchain_s [RD_LAT];

    // Request acceptance; a write on a port suppresses that port's read.
    always_comb begin
        clr_en_s   = (state_r == ST_CLEAR) && (INIT_ZERO != 0) && !reset;
        a_wr_acc_s = a_chipselect && a_write && !wait_r && !reset;
        a_rd_acc_s = a_chipselect && a_read && !a_write && !wait_r && !reset;
        b_wr_acc_s = b_chipselect && b_write && !wait_r && !reset;
        b_rd_acc_s = b_chipselect && b_read && !b_write && !wait_r && !reset;
    end

    // Read sample: old word by default, other port's merged write when forwarding.
    // A reading port is never writing, so only the other port can collide.
    always_comb begin
`ifdef AUDIOSYS_RAM_FWD_EN
        if (b_wr_acc_s && (b_address == a_address)) begin
            a_rd_word_s = merge_lanes(mem_r[a_address], b_writedata, b_byteenable);
        end else begin
            a_rd_word_s = mem_r[a_address];
        end
        if (a_wr_acc_s && (a_address == b_address)) begin
            b_rd_word_s = merge_lanes(mem_r[b_address], a_writedata, a_byteenable);
        end else begin
            b_rd_word_s = mem_r[b_address];
        end
`else
        a_rd_word_s = mem_r[a_address];
        b_rd_word_s = mem_r[b_address];
`endif
    end

    // Stage inputs: stage 0 takes the fresh sample, stage i takes stage i-1.
    always_comb begin
        a_vchain_s[0] = a_rd_acc_s;
        b_vchain_s[0] = b_rd_acc_s;
        a_dchain_s[0] = a_rd_word_s;
        b_dchain_s[0] = b_rd_word_s;
        for (int i = 1; i < RD_LAT; i++) begin
            a_vchain_s[i] = a_pv_r[i-1];
            b_vchain_s[i] = b_pv_r[i-1];
            a_dchain_s[i] = a_pd_r[i-1];
            b_dchain_s[i] = b_pd_r[i-1];
        end
    end

    // Clear/ready sequencer with registered waitrequest and init_done.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_CLEAR;
            clr_addr_r  <= '0;
            wait_r      <= 1'b1;
            init_done_r <= 1'b0;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    if ((INIT_ZERO == 0) || (clr_addr_r == {ADDR_W{1'b1}})) begin
                        state_r     <= ST_READY;
                        clr_addr_r  <= '0;
                        wait_r      <= 1'b0;
                        init_done_r <= 1'b1;
                    end else begin
                        clr_addr_r  <= clr_addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                        wait_r      <= 1'b1;
                        init_done_r <= 1'b0;
                    end
                end
                ST_READY: begin
                    wait_r      <= 1'b0;
                    init_done_r <= 1'b1;
                end
                default: begin
                    state_r     <= ST_CLEAR;
                    clr_addr_r  <= '0;
                    wait_r      <= 1'b1;
                    init_done_r <= 1'b0;
                end
            endcase
        end
    end

    // Memory array: zero fill while clearing; otherwise B lanes then A lanes,
    // so the later assignment gives port A priority on overlapping lanes.
    always_ff @(posedge clk) begin
        if (clr_en_s) begin
            mem_r[clr_addr_r] <= '0;
        end else begin
            if (b_wr_acc_s) begin
                for (int l = 0; l < BE_W; l++) begin
                    if (b_byteenable[l]) begin
                        mem_r[b_address][8*l +: 8] <= b_writedata[8*l +: 8];
                    end
                end
            end
            if (a_wr_acc_s) begin
                for (int l = 0; l < BE_W; l++) begin
                    if (a_byteenable[l]) begin
                        mem_r[a_address][8*l +: 8] <= a_writedata[8*l +: 8];
                    end
                end
            end
        end
    end

    // Read pipelines; data stages only load on valid so the output holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_pv_r <= '0;
            b_pv_r <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                a_pd_r[i] <= '0;
                b_pd_r[i] <= '0;
            end
        end else begin
            a_pv_r <= a_vchain_s;
            b_pv_r <= b_vchain_s;
            for (int i = 0; i < RD_LAT; i++) begin
                if (a_vchain_s[i]) begin
                    a_pd_r[i] <= a_dchain_s[i];
                end
                if (b_vchain_s[i]) begin
                    b_pd_r[i] <= b_dchain_s[i];
                end
            end
        end
    end

    assign a_readdata      = a_pd_r[RD_LAT-1];
    assign a_readdatavalid = a_pv_r[RD_LAT-1];
    assign b_readdata      = b_pd_r[RD_LAT-1];
    assign b_readdatavalid = b_pv_r[RD_LAT-1];
    assign a_waitrequest   = wait_r;
    assign b_waitrequest   = wait_r;
    assign init_done       = init_done_r;

endmodule

// File: tb/tb_audiosystem_ram_dp_pipe.sv
// -----------------------------------------------------------------------------
// Scoreboard bench for audiosystem_ram_dp_pipe (DATA_W=32, ADDR_W=6, RD_LAT=3).
// The driver updates a word-array reference model at issue time and queues the
// expected read word with its due cycle; a monitor compares every cycle.
// -----------------------------------------------------------------------------
module tb_audiosystem_ram_dp_pipe;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 6;
    localparam int RD_LAT = 3;
    localparam int DEPTH  = 64;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [ADDR_W-1:0] a_address = '0, b_address = '0;
    logic              a_chipselect = 1'b0, a_read = 1'b0, a_write = 1'b0;
    logic              b_chipselect = 1'b0, b_read = 1'b0, b_write = 1'b0;
    logic [3:0]        a_byteenable = '0, b_byteenable = '0;
    logic [31:0]       a_writedata = '0, b_writedata = '0;
    logic [31:0]       a_readdata, b_readdata;
    logic              a_readdatavalid, b_readdatavalid;
    logic              a_waitrequest, b_waitrequest;
    logic              init_done;

    audiosystem_ram_dp_pipe #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .INIT_ZERO(1)
    ) dut (
        .clk(clk), .reset(reset),
        .a_address(a_address), .a_chipselect(a_chipselect), .a_read(a_read),
        .a_write(a_write), .a_byteenable(a_byteenable), .a_writedata(a_writedata),
        .a_readdata(a_readdata), .a_readdatavalid(a_readdatavalid),
        .a_waitrequest(a_waitrequest),
        .b_address(b_address), .b_chipselect(b_chipselect), .b_read(b_read),
        .b_write(b_write), .b_byteenable(b_byteenable), .b_writedata(b_writedata),
        .b_readdata(b_readdata), .b_readdatavalid(b_readdatavalid),
        .b_waitrequest(b_waitrequest),
        .init_done(init_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        int          due;
    } exp_t;

    exp_t        qa[$];
    exp_t        qb[$];
    logic [31:0] mdl [DEPTH];
    logic [31:0] last_a = '0, last_b = '0;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int l = 0; l < 4; l++) if (be[l]) r[8*l +: 8] = new_w[8*l +: 8];
        return r;
    endfunction

    // op: 0 idle, 1 read, 2 write, 3 read+write, 4 read+write without chipselect
    task automatic drive(input int aop, input logic [5:0] aad, input logic [3:0] abe,
                         input logic [31:0] awd, input int bop, input logic [5:0] bad,
                         input logic [3:0] bbe, input logic [31:0] bwd);
        logic aw, ar, bw, br;
        logic [31:0] ea, eb;
        @(negedge clk);
        a_chipselect = (aop != 0) && (aop != 4);
        a_read  = (aop == 1) || (aop == 3) || (aop == 4);
        a_write = (aop >= 2);
        a_address = aad; a_byteenable = abe; a_writedata = awd;
        b_chipselect = (bop != 0) && (bop != 4);
        b_read  = (bop == 1) || (bop == 3) || (bop == 4);
        b_write = (bop >= 2);
        b_address = bad; b_byteenable = bbe; b_writedata = bwd;
        if (!reset && !a_waitrequest) begin
            aw = a_chipselect && a_write;
            ar = a_chipselect && a_read && !a_write;
            bw = b_chipselect && b_write;
            br = b_chipselect && b_read && !b_write;
            ea = mdl[aad];
            eb = mdl[bad];
`ifdef AUDIOSYS_RAM_FWD_EN
            if (bw && bad == aad) ea = merge(ea, bwd, bbe);
            if (aw && aad == bad) eb = merge(eb, awd, abe);
`endif
            if (ar) qa.push_back('{d: ea, due: cyc + RD_LAT});
            if (br) qb.push_back('{d: eb, due: cyc + RD_LAT});
            if (bw) mdl[bad] = merge(mdl[bad], bwd, bbe);
            if (aw) mdl[aad] = merge(mdl[aad], awd, abe);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, '0, '0, '0, 0, '0, '0, '0);
    endtask

    // Monitor: reset values, readdatavalid timing, data and hold behaviour.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (reset) begin
            qa.delete(); qb.delete();
            last_a = '0; last_b = '0;
            chk("rst_a_valid", {31'b0, a_readdatavalid}, 32'd0);
            chk("rst_b_valid", {31'b0, b_readdatavalid}, 32'd0);
            chk("rst_a_data", a_readdata, 32'd0);
            chk("rst_b_data", b_readdata, 32'd0);
            chk("rst_wait", {30'b0, a_waitrequest, b_waitrequest}, 32'd3);
            chk("rst_init_done", {31'b0, init_done}, 32'd0);
        end else begin
            if (qa.size() > 0 && qa[0].due == cyc) begin
                chk("a_valid", {31'b0, a_readdatavalid}, 32'd1);
                chk("a_data", a_readdata, qa[0].d);
                last_a = qa[0].d;
                void'(qa.pop_front());
            end else begin
                chk("a_valid_idle", {31'b0, a_readdatavalid}, 32'd0);
                chk("a_hold", a_readdata, last_a);
            end
            if (qb.size() > 0 && qb[0].due == cyc) begin
                chk("b_valid", {31'b0, b_readdatavalid}, 32'd1);
                chk("b_data", b_readdata, qb[0].d);
                last_b = qb[0].d;
                void'(qb.pop_front());
            end else begin
                chk("b_valid_idle", {31'b0, b_readdatavalid}, 32'd0);
                chk("b_hold", b_readdata, last_b);
            end
        end
    end

    initial begin
        int n;
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        // Partial clear with requests that must be stalled.
        for (int i = 0; i < 7; i++) drive(1, 6'(i), 4'hF, 32'hCAFE0000, 2, 6'(i), 4'hF, 32'h55555555);
        chk("init_done_in_clear", {31'b0, init_done}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        a_chipselect = 1'b0; b_chipselect = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        // Restarted clear: count stalled cycles while still issuing requests.
        n = 0;
        while (a_waitrequest && n < 1000) begin
            drive(1, 6'(n), 4'hF, 32'h0, 2, 6'(n), 4'hF, 32'hFFFFFFFF);
            n++;
        end
        chk("clear_cycles", 32'(n), 32'(DEPTH));
        chk("init_done_after_clear", {31'b0, init_done}, 32'd1);
        chk("b_wait_after_clear", {31'b0, b_waitrequest}, 32'd0);
        // Every word reads back zero.
        for (int i = 0; i < DEPTH; i++) drive(1, 6'(i), '0, '0, 1, 6'(DEPTH - 1 - i), '0, '0);
        // Write then read on the next cycle.
        drive(2, 6'h05, 4'hF, 32'hDEADBEEF, 0, '0, '0, '0);
        drive(1, 6'h05, '0, '0, 0, '0, '0, '0);
        idle(5);
        // Byte-lane write.
        drive(2, 6'h10, 4'hF, 32'h11223344, 0, '0, '0, '0);
        drive(2, 6'h10, 4'b0101, 32'hAABBCCDD, 0, '0, '0, '0);
        drive(1, 6'h10, '0, '0, 1, 6'h10, '0, '0);
        // Dual write collision, then read.
        drive(2, 6'h20, 4'b0011, 32'hAAAAAAAA, 2, 6'h20, 4'b0110, 32'hBBBBBBBB);
        drive(1, 6'h20, '0, '0, 0, '0, '0, '0);
        // Mixed-port same-address write/read, both directions.
        drive(2, 6'h30, 4'hF, 32'h12345678, 1, 6'h30, '0, '0);
        drive(1, 6'h31, '0, '0, 2, 6'h31, 4'b1001, 32'h9ABCDEF0);
        // Read+write on one port: read is dropped.
        drive(3, 6'h05, 4'b0010, 32'h00770000, 3, 6'h06, 4'hF, 32'h01020304);
        drive(1, 6'h05, '0, '0, 1, 6'h06, '0, '0);
        // byteenable=0 write leaves word unchanged.
        drive(2, 6'h06, 4'h0, 32'hFFFFFFFF, 0, '0, '0, '0);
        drive(0, '0, '0, '0, 1, 6'h06, '0, '0);
        // Randomised traffic over a small address window to force collisions.
        for (int i = 0; i < 500; i++) begin
            drive($urandom_range(0, 4), 6'($urandom_range(0, 7)), 4'($urandom), $urandom,
                  $urandom_range(0, 4), 6'($urandom_range(0, 7)), 4'($urandom), $urandom);
        end
        idle(RD_LAT + 3);
        chk("a_queue_drained", 32'(qa.size()), 32'd0);
        chk("b_queue_drained", 32'(qb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
